// File: rtl/t03_nes_pkg.sv
// Shared definitions for the NES controller link: state encoding, button
// bit positions inside the 8-bit button vector, and the frame length.
// Used by both the reader (host) side and the responder (device) side.
package t03_nes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } nes_state_t;

    // Bit positions in the active-high button vector; A is shifted out first.
    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    localparam int NES_FRAME_BITS = 8;

endpackage

// File: rtl/t03_nes_controller_responder_if.sv
// The three-wire NES controller link.
//   latch : host -> controller, active-high parallel-load request
//   pulse : host -> controller, shift clock, active on rising edge
//   data  : controller -> host, serial button data, active-low
// master = host/reader side, slave = controller/responder side.
interface t03_nes_controller_responder_if;
    logic latch;
    logic pulse;
    logic data;

    modport master (output latch, output pulse, input data);
    modport slave  (input latch, input pulse, output data);
endinterface

// File: rtl/t03_nes_edge_sync.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall
// detection on the synchronized value.
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous input pin
//   level    : synchronized value
//   rise     : one-cycle strobe on a synchronized 0->1 transition
//   fall     : one-cycle strobe on a synchronized 1->0 transition
// rise/fall are decoded from flops only, so nothing from din reaches them
// combinationally.
module t03_nes_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = sync_q[STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/t03_nes_controller_responder.sv
// Device-side NES controller emulator. Captures the button vector while the
// host holds latch high and shifts it out active-low on data, one bit per
// pulse rising edge, A first.
//   clk, rst   : system clock, synchronous active-high reset
//   buttons    : live button state, active-high (bit 7 = A ... bit 0 = Right)
//   link       : latch/pulse in, data out (slave side of the NES link)
//   busy       : high from latch capture until the frame completes
//   bit_index  : bits already advanced past in this frame (0..8)
//   frame_done : one-cycle strobe when the 8th pulse edge is consumed
module t03_nes_controller_responder
    import t03_nes_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = NES_FRAME_BITS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [7:0]                          buttons,
    t03_nes_controller_responder_if.slave       link,
    output logic                                busy,
    output logic [3:0]                          bit_index,
    output logic                                frame_done
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (FRAME_BITS != NES_FRAME_BITS) begin : g_bad_frame
        $error("FRAME_BITS must be 8 for an NES controller");
    end

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    logic latch_level, latch_rise, latch_fall;
    logic pulse_level, pulse_rise, pulse_fall;
    logic unused_pulse;

    t03_nes_edge_sync #(.STAGES(SYNC_STAGES)) u_latch_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (link.latch),
        .level (latch_level),
        .rise  (latch_rise),
        .fall  (latch_fall)
    );

    t03_nes_edge_sync #(.STAGES(SYNC_STAGES)) u_pulse_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (link.pulse),
        .level (pulse_level),
        .rise  (pulse_rise),
        .fall  (pulse_fall)
    );

    // Only the pulse rise matters; the level and fall are unneeded here.
    assign unused_pulse = pulse_level ^ pulse_fall ^ latch_level;

    nes_state_t state;
    logic [7:0] shadow;
    logic       data_q;

    // data_q is loaded with the inverted MSB of the value shadow is about to
    // take, so a synchronized edge reaches the pin one cycle earlier than a
    // separate output flop after shadow would allow. A latch rise takes
    // priority over everything, including a simultaneous pulse rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shadow     <= 8'h00;
            data_q     <= 1'b1;
            busy       <= 1'b0;
            bit_index  <= 4'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (latch_rise) begin
                state     <= LOAD;
                shadow    <= buttons;
                data_q    <= ~buttons[BTN_A];
                busy      <= 1'b1;
                bit_index <= 4'd0;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    LOAD: begin
                        // Transparent like a 4021 in parallel mode until the
                        // latch falls; the fall cycle itself does not load.
                        if (latch_fall) begin
                            state <= SHIFT;
                        end else begin
                            shadow <= buttons;
                            data_q <= ~buttons[BTN_A];
                        end
                    end
                    SHIFT: begin
                        if (pulse_rise) begin
                            shadow    <= {shadow[6:0], 1'b0};
                            data_q    <= ~shadow[6];
                            bit_index <= bit_index + 4'd1;
                            if (bit_index == LAST_BIT) begin
                                state      <= DONE;
                                frame_done <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        busy <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign link.data = data_q;

endmodule

// File: tb/tb_t03_nes_controller_responder.sv
// Self-checking bench for t03_nes_controller_responder. The stimulus process
// acts as the host (reader) on the NES link and queues expected values; a
// monitor process on the falling clock edge pops and compares them.
module tb_t03_nes_controller_responder;

    localparam int K_DATA  = 0;
    localparam int K_BUSY  = 1;
    localparam int K_INDEX = 2;
    localparam int K_FDCNT = 3;
    localparam int K_FDLVL = 4;
    localparam int K_RDR   = 5;

    typedef struct {
        string      name;
        int         kind;
        logic [7:0] value;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] buttons;
    logic       busy;
    logic [3:0] bit_index;
    logic       frame_done;

    exp_t       exp_q[$];
    int         checks;
    int         failures;
    int         fd_count;
    int         exp_fd;
    logic [7:0] reader_byte;

    t03_nes_controller_responder_if link ();

    t03_nes_controller_responder dut (
        .clk        (clk),
        .rst        (rst),
        .buttons    (buttons),
        .link       (link),
        .busy       (busy),
        .bit_index  (bit_index),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: counts frame_done strobes and compares every queued expectation
    // against the DUT outputs, away from the rising edge.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] act;
        if (frame_done === 1'b1) fd_count++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_DATA:  act = {7'd0, link.data};
                K_BUSY:  act = {7'd0, busy};
                K_INDEX: act = {4'd0, bit_index};
                K_FDCNT: act = fd_count[7:0];
                K_FDLVL: act = {7'd0, frame_done};
                default: act = reader_byte;
            endcase
            checks++;
            if (act !== e.value) begin
                failures++;
                $display("[TB] FAIL %s: got %0h expected %0h", e.name, act, e.value);
            end
        end
    end

    task automatic applyStimulus(input logic l, input logic p, input int cycles);
        link.latch = l;
        link.pulse = p;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int kind, input logic [7:0] value);
        exp_q.push_back('{name, kind, value});
    endtask

    task automatic latchFrame(input logic [7:0] b);
        buttons = b;
        applyStimulus(1'b1, 1'b0, 12);
        applyStimulus(1'b0, 1'b0, 10);
    endtask

    task automatic pulseOnce();
        applyStimulus(1'b0, 1'b1, 10);
        applyStimulus(1'b0, 1'b0, 10);
    endtask

    function automatic logic [7:0] expBit(input logic [7:0] b, input int k);
        return {7'd0, ~b[7-k]};
    endfunction

    initial begin
        checks      = 0;
        failures    = 0;
        fd_count    = 0;
        exp_fd      = 0;
        reader_byte = 8'h00;
        rst         = 1'b1;
        buttons     = 8'h00;
        link.latch  = 1'b0;
        link.pulse  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset_data", K_DATA, 8'h01);
        checkOutput("reset_busy", K_BUSY, 8'h00);
        checkOutput("reset_index", K_INDEX, 8'h00);
        applyStimulus(1'b0, 1'b0, 2);

        // Basic frame, with a latency check on the first pulse edge.
        $display("[TB] basic frame 8'hA1");
        latchFrame(8'hA1);
        checkOutput("basic_busy", K_BUSY, 8'h01);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("basic_bit%0d", k), K_DATA, expBit(8'hA1, k));
            if (k == 0) begin
                applyStimulus(1'b0, 1'b1, 2);
                checkOutput("latency_before", K_DATA, expBit(8'hA1, 0));
                applyStimulus(1'b0, 1'b1, 1);
                checkOutput("latency_after", K_DATA, expBit(8'hA1, 1));
                applyStimulus(1'b0, 1'b1, 7);
                applyStimulus(1'b0, 1'b0, 10);
            end else begin
                pulseOnce();
            end
        end
        exp_fd++;
        checkOutput("basic_end_data", K_DATA, 8'h01);
        checkOutput("basic_end_index", K_INDEX, 8'h08);
        checkOutput("basic_end_busy", K_BUSY, 8'h00);
        checkOutput("basic_fd_count", K_FDCNT, 8'(exp_fd));

        // Reset in the middle of a frame.
        $display("[TB] reset mid-shift");
        latchFrame(8'hC3);
        for (int k = 0; k < 3; k++) pulseOnce();
        checkOutput("mid_index", K_INDEX, 8'h03);
        checkOutput("mid_busy", K_BUSY, 8'h01);
        checkOutput("mid_data", K_DATA, expBit(8'hC3, 3));
        applyStimulus(1'b0, 1'b0, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_data", K_DATA, 8'h01);
        checkOutput("rst_busy", K_BUSY, 8'h00);
        checkOutput("rst_index", K_INDEX, 8'h00);
        checkOutput("rst_fd", K_FDLVL, 8'h00);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 3);

        // Buttons change during and after latch; only the last high value counts.
        $display("[TB] capture timing");
        buttons = 8'hFF;
        applyStimulus(1'b1, 1'b0, 6);
        checkOutput("cap_track_ff", K_DATA, 8'h00);
        checkOutput("cap_busy", K_BUSY, 8'h01);
        buttons = 8'h00;
        applyStimulus(1'b1, 1'b0, 6);
        checkOutput("cap_track_00", K_DATA, 8'h01);
        applyStimulus(1'b0, 1'b0, 5);
        buttons = 8'hFF;
        applyStimulus(1'b0, 1'b0, 5);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("cap_bit%0d", k), K_DATA, 8'h01);
            pulseOnce();
        end
        exp_fd++;
        checkOutput("cap_fd_count", K_FDCNT, 8'(exp_fd));

        // Twelve pulses after one latch: extras are ignored.
        $display("[TB] extra pulses 8'h5A");
        latchFrame(8'h5A);
        for (int k = 0; k < 12; k++) begin
            if (k < 8) begin
                checkOutput($sformatf("extra_bit%0d", k), K_DATA, expBit(8'h5A, k));
            end else begin
                checkOutput($sformatf("extra_idle%0d", k), K_DATA, 8'h01);
                checkOutput($sformatf("extra_index%0d", k), K_INDEX, 8'h08);
            end
            pulseOnce();
        end
        exp_fd++;
        checkOutput("extra_index_end", K_INDEX, 8'h08);
        checkOutput("extra_fd_count", K_FDCNT, 8'(exp_fd));

        // Relatch after four pulses aborts the frame without frame_done.
        $display("[TB] relatch abort");
        latchFrame(8'h80);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("abort_bit%0d", k), K_DATA, expBit(8'h80, k));
            pulseOnce();
        end
        checkOutput("abort_index4", K_INDEX, 8'h04);
        checkOutput("abort_data4", K_DATA, 8'h01);
        applyStimulus(1'b1, 1'b0, 12);
        checkOutput("relatch_data", K_DATA, 8'h00);
        checkOutput("relatch_index", K_INDEX, 8'h00);
        checkOutput("relatch_busy", K_BUSY, 8'h01);
        applyStimulus(1'b0, 1'b0, 10);
        checkOutput("abort_fd_count", K_FDCNT, 8'(exp_fd));

        // Loopback: the bench plays the reader and decodes the frame.
        $display("[TB] loopback 8'h3C");
        latchFrame(8'h3C);
        reader_byte = 8'h00;
        for (int k = 0; k < 8; k++) begin
            reader_byte[7-k] = ~link.data;
            pulseOnce();
        end
        exp_fd++;
        checkOutput("loopback_byte", K_RDR, 8'h3C);
        checkOutput("loopback_fd_count", K_FDCNT, 8'(exp_fd));

        applyStimulus(1'b0, 1'b0, 3);
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        failures++;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/t03_nes_controller_responder.md
Name: t03_nes_controller_responder

Overview:
- Device-side NES controller emulator: the other end of the latch/pulse/serial-data link that the team's NES controller reader drives.
- Captures an 8-bit button vector on latch and shifts it out active-low on `data`, one bit per pulse rising edge, in NES order (A first).
- Used as an on-chip stand-in controller for self-test, loopback and bench stimulus of the reader; also usable to expose this design as a controller to an external host.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on the latch and pulse inputs (minimum 2).
- FRAME_BITS, 8, bits per frame; fixed at 8 for NES and kept as a parameter only for range checks.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- buttons  input  8  live button state, active-high. Bit 7=A, 6=B, 5=Select, 4=Start, 3=Up, 2=Down, 1=Left, 0=Right.
- latch  input  1  host latch, asynchronous to clk, active-high
- pulse  input  1  host shift clock, asynchronous to clk, active on rising edge
- data  output  1  serial button data, active-low (0 = pressed)
- busy  output  1  high from latch capture until the frame completes
- bit_index  output  4  number of bits already advanced past in the current frame (0..8)
- frame_done  output  1  one-cycle strobe when the 8th pulse edge is consumed

Behaviour:
- Input conditioning
  - latch and pulse each pass through SYNC_STAGES flops; all synchronizer flops reset to 0.
  - Rise and fall detection on the synchronized value against a one-cycle-delayed copy.
- State register (states IDLE, LOAD, SHIFT, DONE) and an 8-bit shadow register; shadow resets to 8'h00.
- data is always ~shadow[7], registered. After reset this gives data=1.
- IDLE:
  - busy=0, shadow held.
  - A latch rise goes to LOAD.
- LOAD (synchronized latch high):
  - shadow <= buttons every cycle, so data tracks ~buttons[7] like a parallel-mode 4021.
  - bit_index=0, busy=1.
  - A latch fall goes to SHIFT. The shadow freezes at the value loaded on the last latch-high cycle.
- SHIFT:
  - On each pulse rise: shadow <= {shadow[6:0],1'b0} and bit_index += 1.
  - Bit k (k=0..7) is presented after k pulse rises.
  - When the rise brings bit_index to 8: go to DONE, assert frame_done for exactly that cycle, busy drops the next cycle.
  - buttons changes are ignored.
- DONE:
  - data=1 (shadow is all zeros), bit_index holds 8, busy=0.
  - Further pulse rises are ignored; bit_index saturates at 8.
  - A latch rise goes to LOAD.
- Priority
  - A latch rise in any state forces LOAD and aborts any frame in progress. frame_done is not asserted for an aborted frame.
  - While latch is high, pulse edges are ignored.
  - If a latch rise and a pulse rise occur in the same cycle, latch wins.
- Latency: a pin edge on latch or pulse appears on data within SYNC_STAGES+1 clk cycles. The host pulse half-period must exceed SYNC_STAGES+2 clk cycles.
- Reset mid-frame: next cycle state=IDLE, shadow=0, data=1, busy=0, bit_index=0, frame_done=0.
- No combinational path from any input to any output.

Decomposition:
- Shared package t03_nes_pkg holds:
  - state enum (IDLE, LOAD, SHIFT, DONE)
  - button index constants BTN_A=7 through BTN_RIGHT=0
  - NES_FRAME_BITS=8
- Both the reader side and this block use the package.
- One sub-module: t03_nes_edge_sync (SYNC_STAGES synchronizer plus rise/fall outputs), instantiated twice, for latch and pulse.

Test Plan:
- Reset: assert rst mid-SHIFT after 3 pulses -> next cycle data=1, busy=0, bit_index=0, frame_done=0.
- Basic frame: buttons=8'b1010_0001, latch high 12 cycles then low, 8 pulses of 10 cycles high / 10 low.
  - Sampled data before each pulse reads 0,1,0,1,1,1,1,0.
  - frame_done pulses once on the 8th rise; afterwards data=1.
- Capture timing: change buttons from 8'hFF to 8'h00 while latch is high, then to 8'hFF after the latch fall -> shifted frame is all 1s on data (none pressed).
- Extra pulses: 12 pulses after one latch -> bits 0..7 as loaded, then data=1, bit_index stays 8, frame_done asserted exactly once.
- Relatch abort: latch after 4 pulses with buttons=8'h80 -> data=0 immediately after LOAD, bit_index=0, no frame_done for the aborted frame.
- Loopback: drive the team's NES controller reader's latch/pulse into this block with buttons=8'h3C -> the reader's decoded player-1 byte equals 8'h3C (active-high) after one reader frame.
